// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared types and helpers for the LDPC check-node datapath
package ldpc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } cn_state_e;

    // Largest representable magnitude for a qw-bit symmetric message.
    function automatic int maxm(input int qw);
        return (1 << (qw - 1)) - 1;
    endfunction

    // Clip a sign-extended message into [-MAXM, MAXM] so negation never overflows.
    function automatic logic signed [16:0] sat_sym(input logic signed [16:0] x, input int qw);
        int m;
        int xv;
        m  = maxm(qw);
        xv = int'(x);
        if (xv > m) begin
            xv = m;
        end else if (xv < -m) begin
            xv = -m;
        end
        return 17'(xv);
    endfunction

endpackage

// File: rtl/ldpc_cn_lane.sv
// rtl/ldpc_cn_lane.sv - one check node: min1/min2/sign accumulation and extrinsic output
module ldpc_cn_lane #(
    parameter int QW    = 8,
    parameter int IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             init_i,
    input  logic             acc_i,
    input  logic [IDX_W-1:0] k_i,
    input  logic [QW-1:0]    x_i,
    input  logic [QW-2:0]    offset_i,
    output logic [QW-1:0]    y_o
);
    import ldpc_pkg::*;

    localparam int            DEPTH = 1 << IDX_W;
    localparam logic [QW-2:0] MAXM  = (QW-1)'(maxm(QW));

    logic signed [QW-1:0] v;
    logic                 sgn;
    logic [QW-2:0]        mag;

    logic [QW-2:0]        min1_q;
    logic [QW-2:0]        min2_q;
    logic [IDX_W-1:0]     idx1_q;
    logic                 parity_q;
    logic [DEPTH-1:0]     sign_q;

    logic [QW-2:0]        m;
    logic [QW-2:0]        m_off;
    logic                 s;

    // Clip the incoming message and split it into sign and magnitude.
    always_comb begin
        v   = QW'(sat_sym({{(17-QW){x_i[QW-1]}}, x_i}, QW));
        sgn = v[QW-1];
        mag = (QW-1)'(sgn ? -v : v);
    end

    // Track the two smallest magnitudes, where the smallest sits, and all signs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            min1_q   <= MAXM;
            min2_q   <= MAXM;
            idx1_q   <= '0;
            parity_q <= 1'b0;
            sign_q   <= '0;
        end else if (init_i) begin
            min1_q   <= MAXM;
            min2_q   <= MAXM;
            idx1_q   <= '0;
            parity_q <= 1'b0;
            sign_q   <= '0;
        end else if (acc_i) begin
            sign_q[k_i] <= sgn;
            parity_q    <= parity_q ^ sgn;
            if (mag < min1_q) begin
                min2_q <= min1_q;
                min1_q <= mag;
                idx1_q <= k_i;
            end else if (mag < min2_q) begin
                min2_q <= mag;
            end
        end
    end

    // Extrinsic message for edge k: exclude its own contribution, apply offset.
    always_comb begin
        m     = (k_i == idx1_q) ? min2_q : min1_q;
        m_off = (m > offset_i) ? (m - offset_i) : '0;
        s     = parity_q ^ sign_q[k_i];
        y_o   = s ? -{1'b0, m_off} : {1'b0, m_off};
    end

endmodule

// File: rtl/ldpc_cn_minsum.sv
// rtl/ldpc_cn_minsum.sv - multi-lane offset-min-sum check-node update engine
module ldpc_cn_minsum #(
    parameter  int QW      = 8,
    parameter  int LANES   = 4,
    parameter  int MAX_DEG = 32,
    localparam int IDX_W   = $clog2(MAX_DEG)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [IDX_W:0]      degree_i,
    input  logic [QW-2:0]       offset_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [LANES*QW-1:0] in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [LANES*QW-1:0] out_data_o,
    output logic                out_last_o,
    output logic                busy_o,
    output logic                cfg_err_o
);
    import ldpc_pkg::*;

    localparam logic [IDX_W:0] MAX_DEG_W = (IDX_W+1)'(MAX_DEG);
    localparam logic [IDX_W:0] MIN_DEG_W = (IDX_W+1)'(2);
    localparam logic [IDX_W:0] ONE_W     = (IDX_W+1)'(1);

    cn_state_e          state_q;
    cn_state_e          state_d;
    logic [IDX_W-1:0]   k_q;
    logic [IDX_W:0]     deg_q;
    logic [QW-2:0]      off_q;
    logic               cfg_err_q;

    logic               cfg_legal;
    logic               k_last;
    logic               start_ok;
    logic               cfg_bad;
    logic               acc;
    logic               hs;
    logic [LANES*QW-1:0] lane_data;

    assign cfg_legal = (degree_i >= MIN_DEG_W) && (degree_i <= MAX_DEG_W);
    assign k_last    = ({1'b0, k_q} == (deg_q - ONE_W));

    // Next-state and handshake decode.
    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        start_ok    = 1'b0;
        cfg_bad     = 1'b0;
        acc         = 1'b0;
        hs          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (cfg_legal) begin
                        start_ok = 1'b1;
                        state_d  = ACCUM;
                    end else begin
                        cfg_bad = 1'b1;
                    end
                end
            end
            ACCUM: begin
                in_ready_o = 1'b1;
                acc        = in_valid_i;
                if (acc && k_last) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                out_valid_o = 1'b1;
                hs          = out_ready_i;
                if (hs && k_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, edge counter, latched configuration and error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            k_q       <= '0;
            deg_q     <= '0;
            off_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= cfg_bad;
            if (start_ok) begin
                k_q   <= '0;
                deg_q <= degree_i;
                off_q <= offset_i;
            end else if (acc || hs) begin
                k_q <= k_last ? '0 : (k_q + IDX_W'(1));
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        ldpc_cn_lane #(
            .QW    (QW),
            .IDX_W (IDX_W)
        ) u_lane (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .init_i   (start_ok),
            .acc_i    (acc),
            .k_i      (k_q),
            .x_i      (in_data_i[l*QW +: QW]),
            .offset_i (off_q),
            .y_o      (lane_data[l*QW +: QW])
        );
    end

    assign out_data_o = out_valid_o ? lane_data : '0;
    assign out_last_o = out_valid_o && k_last;
    assign busy_o     = (state_q != IDLE);
    assign cfg_err_o  = cfg_err_q;

endmodule

// File: tb/tb_ldpc_cn_minsum.sv
// tb/tb_ldpc_cn_minsum.sv - self-checking bench for ldpc_cn_minsum
module tb_ldpc_cn_minsum;
    localparam int QW      = 8;
    localparam int LANES   = 4;
    localparam int MAX_DEG = 32;
    localparam int IDX_W   = 5;
    localparam int MAXM    = 127;

    logic                clk_i       = 1'b0;
    logic                rst_ni      = 1'b0;
    logic                start_i     = 1'b0;
    logic [IDX_W:0]      degree_i    = '0;
    logic [QW-2:0]       offset_i    = '0;
    logic                in_valid_i  = 1'b0;
    logic                in_ready_o;
    logic [LANES*QW-1:0] in_data_i   = '0;
    logic                out_valid_o;
    logic                out_ready_i = 1'b0;
    logic [LANES*QW-1:0] out_data_o;
    logic                out_last_o;
    logic                busy_o;
    logic                cfg_err_o;

    ldpc_cn_minsum #(.QW(QW), .LANES(LANES), .MAX_DEG(MAX_DEG)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .degree_i    (degree_i),
        .offset_i    (offset_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .cfg_err_o   (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int in_vals  [LANES][MAX_DEG];
    int exp_vals [LANES][MAX_DEG];

    typedef struct {
        int deg;
        int off;
        int x[4];
        int y[4];
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int clip(input int x);
        if (x > MAXM) return MAXM;
        if (x < -MAXM) return -MAXM;
        return x;
    endfunction

    // Extrinsic reference: each edge sees the min magnitude and sign product of all other edges.
    task automatic model(input int deg, input int off);
        for (int l = 0; l < LANES; l++) begin
            for (int j = 0; j < deg; j++) begin
                int s;
                int m;
                int mp;
                s = 0;
                m = MAXM;
                for (int i = 0; i < deg; i++) begin
                    if (i != j) begin
                        int v;
                        v = clip(in_vals[l][i]);
                        if (v < 0) s = s ^ 1;
                        if ((v < 0 ? -v : v) < m) m = (v < 0 ? -v : v);
                    end
                end
                mp = (m > off) ? m - off : 0;
                exp_vals[l][j] = s ? -mp : mp;
            end
        end
    endtask

    task automatic run_update(input int deg, input int off, input int gap_pct,
                              input int rdy_mode, input int abort_after);
        int  b;
        int  e;
        int  cyc;
        bit  in_rdy;
        bit  vld;
        bit  rdy;
        bit  saw_ready_hi;
        @(negedge clk_i);
        start_i  = 1'b1;
        degree_i = (IDX_W+1)'(deg);
        offset_i = (QW-1)'(off);
        @(negedge clk_i);
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        b   = 0;
        cyc = 0;
        while (b < deg && cyc < 2000) begin
            in_rdy = in_ready_o;
            if ($urandom_range(99) < gap_pct) begin
                in_valid_i = 1'b0;
            end else begin
                in_valid_i = 1'b1;
                for (int l = 0; l < LANES; l++) in_data_i[l*QW +: QW] = QW'(in_vals[l][b]);
            end
            @(negedge clk_i);
            if (in_valid_i && in_rdy) b++;
            cyc++;
        end
        in_valid_i = 1'b0;
        if (b < deg) check("accum_timeout", b, deg);
        check("turnaround_valid", out_valid_o, 1);
        e            = 0;
        cyc          = 0;
        saw_ready_hi = 1'b0;
        while (e < deg && cyc < 2000) begin
            if (abort_after >= 0 && e == abort_after) break;
            if (in_ready_o) saw_ready_hi = 1'b1;
            vld = out_valid_o;
            check("out_valid_emit", vld, 1);
            if (vld) begin
                for (int l = 0; l < LANES; l++)
                    check($sformatf("data l%0d e%0d", l, e), $signed(out_data_o[l*QW +: QW]), exp_vals[l][e]);
                check($sformatf("last e%0d", e), out_last_o, int'(e == deg - 1));
            end
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(1));
            endcase
            out_ready_i = rdy;
            @(negedge clk_i);
            if (rdy && vld) e++;
            cyc++;
        end
        out_ready_i = 1'b0;
        if (abort_after < 0) begin
            if (e < deg) check("emit_timeout", e, deg);
            check("in_ready_in_emit", saw_ready_hi, 0);
            check("idle_after_update", busy_o, 0);
        end
    endtask

    task automatic cfg_bad(input int deg);
        @(negedge clk_i);
        start_i  = 1'b1;
        degree_i = (IDX_W+1)'(deg);
        @(negedge clk_i);
        start_i = 1'b0;
        check($sformatf("cfg_err_pulse d%0d", deg), cfg_err_o, 1);
        check($sformatf("cfg_busy d%0d", deg), busy_o, 0);
        @(negedge clk_i);
        check($sformatf("cfg_err_single d%0d", deg), cfg_err_o, 0);
        check($sformatf("cfg_busy2 d%0d", deg), busy_o, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].deg = 4; vecs[0].off = 0; vecs[0].x = '{5, -3, 10, -128}; vecs[0].y = '{3, -5, 3, -3};
        vecs[1].deg = 4; vecs[1].off = 1; vecs[1].x = '{5, -3, 10, -128}; vecs[1].y = '{2, -4, 2, -2};
        vecs[2].deg = 4; vecs[2].off = 4; vecs[2].x = '{5, -3, 10, -128}; vecs[2].y = '{0, -1, 0, 0};
        vecs[3].deg = 3; vecs[3].off = 0; vecs[3].x = '{7, 7, 9, 0};      vecs[3].y = '{7, 7, 7, 0};

        repeat (2) @(negedge clk_i);
        check("rst out_valid", out_valid_o, 0);
        check("rst in_ready", in_ready_o, 0);
        check("rst busy", busy_o, 0);
        check("rst cfg_err", cfg_err_o, 0);
        check("rst out_last", out_last_o, 0);
        check("rst out_data", int'(out_data_o), 0);
        rst_ni = 1'b1;

        for (int t = 0; t < 4; t++) begin
            for (int l = 0; l < LANES; l++)
                for (int j = 0; j < vecs[t].deg; j++) begin
                    in_vals[l][j]  = vecs[t].x[j];
                    exp_vals[l][j] = vecs[t].y[j];
                end
            run_update(vecs[t].deg, vecs[t].off, 0, 0, -1);
        end

        for (int l = 0; l < LANES; l++)
            for (int j = 0; j < 6; j++) in_vals[l][j] = int'($urandom_range(255)) - 128;
        model(6, 3);
        run_update(6, 3, 0, 1, -1);

        cfg_bad(1);
        cfg_bad(MAX_DEG + 1);

        for (int l = 0; l < LANES; l++)
            for (int j = 0; j < MAX_DEG; j++) begin
                in_vals[l][j]  = -1;
                exp_vals[l][j] = -1;
            end
        run_update(MAX_DEG, 0, 20, 2, -1);

        for (int l = 0; l < LANES; l++) begin
            in_vals[l][0] = -2; in_vals[l][1] = 9; in_vals[l][2] = -4; in_vals[l][3] = 1;
        end
        model(4, 0);
        run_update(4, 0, 0, 0, 2);
        rst_ni = 1'b0;
        #1;
        check("abort out_valid", out_valid_o, 0);
        check("abort out_data", int'(out_data_o), 0);
        check("abort out_last", out_last_o, 0);
        check("abort busy", busy_o, 0);
        check("abort in_ready", in_ready_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            in_vals[l][0] = 50; in_vals[l][1] = 60 + l; in_vals[l][2] = 70; in_vals[l][3] = 80;
        end
        model(4, 0);
        run_update(4, 0, 0, 0, -1);

        for (int r = 0; r < 20; r++) begin
            int deg;
            int off;
            deg = int'($urandom_range(MAX_DEG, 2));
            off = (r % 4 == 0) ? int'($urandom_range(127)) : int'($urandom_range(20));
            for (int l = 0; l < LANES; l++)
                for (int j = 0; j < deg; j++) in_vals[l][j] = int'($urandom_range(255)) - 128;
            model(deg, off);
            run_update(deg, off, 30, 2, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
